// File: rtl/uart_cfg_core.sv
// uart_cfg_core: parametrised full-duplex UART.
// Transmit side takes words over valid/ready. Receive side oversamples at 16x
// with a 3-sample majority vote and delivers words into a one-entry holding
// register that carries parity, framing and overrun status.
module uart_cfg_core #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int             DIV        = CLK_HZ / (BAUD * 16);
  localparam int             CW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  DIV_LAST   = CW'(DIV - 1);
  localparam logic [2:0]     DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]     STOP_LAST  = 3'(STOP_BITS - 1);
  localparam bit             HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Shared 16x tick
  // ---------------------------------------------------------------------------
  logic [CW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == DIV_LAST);

  // Free-running divider, one tick per 1/16 bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_e               tx_state_q, tx_state_d;
  logic [3:0]           tx_sub_q, tx_sub_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;

  // TX state register; tx line is forced high the moment reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_sub_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sub_q   <= tx_sub_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state: the registered line value is prepared one bit ahead.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sub_d   = tx_sub_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      S_IDLE: begin
        if (tx_valid) begin
          tx_state_d = S_START;
          tx_sub_d   = '0;
          tx_shift_d = tx_data;
          tx_par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          tx_sub_d = tx_sub_q + 4'd1;
          if (tx_sub_q == 4'd15) begin
            tx_state_d = S_DATA;
            tx_bit_d   = '0;
            tx_d       = tx_shift_q[0];
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          tx_sub_d = tx_sub_q + 4'd1;
          if (tx_sub_q == 4'd15) begin
            if (tx_bit_q == DATA_LAST) begin
              if (HAS_PARITY) begin
                tx_state_d = S_PARITY;
                tx_d       = tx_par_q;
              end else begin
                tx_state_d = S_STOP;
                tx_bit_d   = '0;
                tx_d       = 1'b1;
              end
            end else begin
              tx_bit_d   = tx_bit_q + 3'd1;
              tx_shift_d = tx_shift_q >> 1;
              tx_d       = tx_shift_q[1];
            end
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          tx_sub_d = tx_sub_q + 4'd1;
          if (tx_sub_q == 4'd15) begin
            tx_state_d = S_STOP;
            tx_bit_d   = '0;
            tx_d       = 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          tx_sub_d = tx_sub_q + 4'd1;
          if (tx_sub_q == 4'd15) begin
            if (tx_bit_q == STOP_LAST) tx_state_d = S_IDLE;
            else                       tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = (tx_state_q == S_IDLE);

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  state_e               rx_state_q, rx_state_d;
  logic [3:0]           rx_sub_q, rx_sub_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_s7_q, rx_s7_d;
  logic                 rx_s8_q, rx_s8_d;
  logic                 rx_pbit_q, rx_pbit_d;
  logic                 rx_maj;
  logic                 rx_done;
  logic                 rx_done_ferr;
  logic                 rx_done_perr;

  assign rx_maj = (rx_s7_q & rx_s8_q) | (rx_s7_q & rx_sync_q) | (rx_s8_q & rx_sync_q);

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= S_IDLE;
      rx_sub_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s7_q    <= 1'b1;
      rx_s8_q    <= 1'b1;
      rx_pbit_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sub_q   <= rx_sub_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s7_q    <= rx_s7_d;
      rx_s8_q    <= rx_s8_d;
      rx_pbit_q  <= rx_pbit_d;
    end
  end

  // RX next state: samples 7/8/9 vote per bit; the frame ends mid stop bit.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_sub_d     = rx_sub_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_s7_d      = rx_s7_q;
    rx_s8_d      = rx_s8_q;
    rx_pbit_d    = rx_pbit_q;
    rx_done      = 1'b0;
    rx_done_ferr = 1'b0;
    if (PARITY == 1)      rx_done_perr = ~(^rx_shift_q ^ rx_pbit_q);
    else if (PARITY == 2) rx_done_perr = ^rx_shift_q ^ rx_pbit_q;
    else                  rx_done_perr = 1'b0;

    if (tick) begin
      if (rx_sub_q == 4'd7) rx_s7_d = rx_sync_q;
      if (rx_sub_q == 4'd8) rx_s8_d = rx_sync_q;
      unique case (rx_state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_d = S_START;
            rx_sub_d   = '0;
          end
        end
        S_START: begin
          rx_sub_d = rx_sub_q + 4'd1;
          if (rx_sub_q == 4'd7 && rx_sync_q) begin
            rx_state_d = S_IDLE;
            rx_sub_d   = '0;
          end else if (rx_sub_q == 4'd15) begin
            rx_state_d = S_DATA;
            rx_bit_d   = '0;
          end
        end
        S_DATA: begin
          rx_sub_d = rx_sub_q + 4'd1;
          if (rx_sub_q == 4'd9) rx_shift_d = {rx_maj, rx_shift_q[DATA_BITS-1:1]};
          if (rx_sub_q == 4'd15) begin
            if (rx_bit_q == DATA_LAST) rx_state_d = HAS_PARITY ? S_PARITY : S_STOP;
            else                       rx_bit_d   = rx_bit_q + 3'd1;
          end
        end
        S_PARITY: begin
          rx_sub_d = rx_sub_q + 4'd1;
          if (rx_sub_q == 4'd9)  rx_pbit_d  = rx_maj;
          if (rx_sub_q == 4'd15) rx_state_d = S_STOP;
        end
        S_STOP: begin
          rx_sub_d = rx_sub_q + 4'd1;
          if (rx_sub_q == 4'd9) begin
            rx_done      = 1'b1;
            rx_done_ferr = ~rx_maj;
            rx_state_d   = S_IDLE;
            rx_sub_d     = '0;
          end
        end
        default: rx_state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive holding register
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;

  // Holding register next state: a new frame may replace a word consumed this cycle.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;
    if (rx_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shift_q;
        rx_perr_d  = rx_done_perr;
        rx_ferr_d  = rx_done_ferr;
        rx_valid_d = 1'b1;
        rx_ovr_d   = 1'b0;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_cfg_core.sv
// Testbench for uart_cfg_core: three instances (8N1, 7E2 loopback, 8O1) at
// 16 clocks per bit, checked against a frame-level reference model.
module tb_uart_cfg_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // 8N1 instance (TX checks, bench-driven RX for overrun)
  logic [7:0] a_tx_data = '0;
  logic       a_tx_valid = 1'b0, a_tx_ready, a_tx;
  logic       a_rx = 1'b1, a_rx_ready = 1'b0;
  logic [7:0] a_rx_data;
  logic       a_rx_valid, a_perr, a_ferr, a_ovr;

  // 7E2 instance, tx looped to rx
  logic [6:0] l_tx_data = '0;
  logic       l_tx_valid = 1'b0, l_tx_ready, l_tx;
  logic       l_rx_ready = 1'b0;
  logic [6:0] l_rx_data;
  logic       l_rx_valid, l_perr, l_ferr, l_ovr;

  // 8O1 instance, bench-driven RX
  logic [7:0] o_tx_data = '0;
  logic       o_tx_valid = 1'b0, o_tx_ready, o_tx;
  logic       o_rx = 1'b1, o_rx_ready = 1'b0;
  logic [7:0] o_rx_data;
  logic       o_rx_valid, o_perr, o_ferr, o_ovr;

  uart_cfg_core #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx(a_tx), .rx(a_rx), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_parity_err(a_perr), .rx_frame_err(a_ferr), .rx_overrun(a_ovr));

  uart_cfg_core #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_l (
    .clk(clk), .rst_n(rst_n), .tx_data(l_tx_data), .tx_valid(l_tx_valid), .tx_ready(l_tx_ready),
    .tx(l_tx), .rx(l_tx), .rx_data(l_rx_data), .rx_valid(l_rx_valid), .rx_ready(l_rx_ready),
    .rx_parity_err(l_perr), .rx_frame_err(l_ferr), .rx_overrun(l_ovr));

  uart_cfg_core #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .tx_data(o_tx_data), .tx_valid(o_tx_valid), .tx_ready(o_tx_ready),
    .tx(o_tx), .rx(o_rx), .rx_data(o_rx_data), .rx_valid(o_rx_valid), .rx_ready(o_rx_ready),
    .rx_parity_err(o_perr), .rx_frame_err(o_ferr), .rx_overrun(o_ovr));

  // Reference model: serial bit sequence of a frame, index 0 = start bit.
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input int nb, input int par,
                                           input bit flip_par, input bit bad_stop);
    logic [15:0] f;
    int ones;
    int n;
    f = 16'hFFFF;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    n = 1 + nb;
    if (par != 0) begin
      f[n] = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      if (flip_par) f[n] = ~f[n];
      n++;
    end
    if (bad_stop) f[n] = 1'b0;
    return f;
  endfunction

  function automatic int frame_len(input int nb, input int par, input int stops);
    return 1 + nb + ((par != 0) ? 1 : 0) + stops;
  endfunction

  // Drive a serial frame (bits 16 cycles each, then 40 idle cycles) into the
  // 8N1 (which=0) or 8O1 (which=1) receiver; reports rx_valid edges seen.
  task automatic drive_line(input int which, input logic [15:0] bits, input int len,
                            input int glitch_at, input int ready_at, input int rst_at,
                            output int rise_at, output int fall_at);
    logic pv, v, val;
    int nb;
    nb = len * 16;
    rise_at = -1;
    fall_at = -1;
    pv = (which == 0) ? a_rx_valid : o_rx_valid;
    for (int i = 0; i < nb + 40; i++) begin
      @(negedge clk);
      v = (which == 0) ? a_rx_valid : o_rx_valid;
      if (!pv && v && rise_at < 0) rise_at = i;
      if (pv && !v && fall_at < 0) fall_at = i;
      pv = v;
      val = (i < nb) ? bits[i/16] : 1'b1;
      if (i == glitch_at) val = ~val;
      if (which == 0) begin
        a_rx = val;
        a_rx_ready = (i == ready_at);
      end else begin
        o_rx = val;
        o_rx_ready = (i == ready_at);
      end
      if (i == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && i == nb + 4) rst_n = 1'b1;
    end
  endtask

  task automatic pulse_ready(input int which);
    @(negedge clk);
    if (which == 0) a_rx_ready = 1'b1; else o_rx_ready = 1'b1;
    @(negedge clk);
    if (which == 0) a_rx_ready = 1'b0; else o_rx_ready = 1'b0;
  endtask

  // Send one word on the 8N1 transmitter and compare the whole waveform.
  task automatic send_tx_a(input logic [7:0] d, input string nm);
    logic [15:0] f;
    int t, errs, rdy_hi;
    f = mk_frame(d, 8, 0, 1'b0, 1'b0);
    @(negedge clk);
    a_tx_data = d;
    a_tx_valid = 1'b1;
    t = 0;
    while (!a_tx_ready && t < 400) begin @(negedge clk); t++; end
    @(negedge clk);
    a_tx_valid = 1'b0;
    errs = 0;
    rdy_hi = 0;
    for (int k = 0; k < 160; k++) begin
      if (k > 0) @(negedge clk);
      if (a_tx !== f[k/16]) errs++;
      if (a_tx_ready) rdy_hi++;
    end
    chk_cnt++;
    if (errs != 0 || t >= 400) $display("FAIL %s data=%02h: %0d wrong tx cycles (wait %0d), required 0", nm, d, errs, t);
    else pass_cnt++;
    chk_cnt++;
    if (rdy_hi != 0) $display("FAIL %s_ready: tx_ready high %0d cycles in frame, required 0", nm, rdy_hi);
    else pass_cnt++;
    @(negedge clk);
    $display("tx %s data=%02h errs=%0d", nm, d, errs);
  endtask

  task automatic test_reset;
    int toggles;
    logic pa, pl, po;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({a_tx, a_tx_ready, l_tx, l_tx_ready, o_tx, o_tx_ready} !== 6'b111111)
      $display("FAIL reset_tx: tx/ready=%b, required 111111", {a_tx, a_tx_ready, l_tx, l_tx_ready, o_tx, o_tx_ready});
    else pass_cnt++;
    chk_cnt++;
    if ({a_rx_valid, a_perr, a_ferr, a_ovr, o_rx_valid, o_perr, o_ferr, o_ovr, l_rx_valid} !== 9'b0)
      $display("FAIL reset_rx_flags: got %b, required 0", {a_rx_valid, a_perr, a_ferr, a_ovr, o_rx_valid, o_perr, o_ferr, o_ovr, l_rx_valid});
    else pass_cnt++;
    chk_cnt++;
    if (a_rx_data !== 8'h00 || o_rx_data !== 8'h00 || l_rx_data !== 7'h00)
      $display("FAIL reset_rx_data: got %02h/%02h/%02h, required 00", a_rx_data, o_rx_data, l_rx_data);
    else pass_cnt++;
    toggles = 0;
    pa = a_tx; pl = l_tx; po = o_tx;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (a_tx !== pa || l_tx !== pl || o_tx !== po || a_rx_valid || o_rx_valid || l_rx_valid) toggles++;
      pa = a_tx; pl = l_tx; po = o_tx;
    end
    chk_cnt++;
    if (toggles != 0) $display("FAIL reset_idle: %0d activity cycles in 1000, required 0", toggles);
    else pass_cnt++;
    $display("reset idle activity=%0d", toggles);
  endtask

  task automatic test_tx_8n1;
    logic [7:0] w2;
    logic [15:0] f1, f2;
    int t, errs1, errs2, rdy_hi;
    w2 = 8'($urandom);
    f1 = mk_frame(8'hA5, 8, 0, 1'b0, 1'b0);
    f2 = mk_frame(w2, 8, 0, 1'b0, 1'b0);
    @(negedge clk);
    a_tx_data = 8'hA5;
    a_tx_valid = 1'b1;
    t = 0;
    while (!a_tx_ready && t < 400) begin @(negedge clk); t++; end
    @(negedge clk);                      // k = 0: first word accepted
    a_tx_data = w2;                      // second word offered while busy
    errs1 = 0;
    rdy_hi = 0;
    for (int k = 0; k < 160; k++) begin
      if (k > 0) @(negedge clk);
      if (a_tx !== f1[k/16]) errs1++;
      if (a_tx_ready) rdy_hi++;
    end
    chk_cnt++;
    if (errs1 != 0) $display("FAIL tx_a5_wave: %0d wrong cycles, required 0", errs1);
    else pass_cnt++;
    chk_cnt++;
    if (rdy_hi != 0) $display("FAIL tx_a5_busy: ready high %0d cycles, required 0", rdy_hi);
    else pass_cnt++;
    @(negedge clk);                      // k = 160
    chk_cnt++;
    if (a_tx_ready !== 1'b1 || a_tx !== 1'b1) $display("FAIL tx_a5_end: ready=%b tx=%b, required 1 1", a_tx_ready, a_tx);
    else pass_cnt++;
    errs2 = 0;
    rdy_hi = 0;
    for (int j = 0; j < 160; j++) begin
      @(negedge clk);                    // k = 161 + j
      if (j == 0) a_tx_valid = 1'b0;
      if (a_tx !== f2[j/16]) errs2++;
      if (a_tx_ready) rdy_hi++;
    end
    chk_cnt++;
    if (errs2 != 0 || rdy_hi != 0) $display("FAIL tx_b2b: word %02h %0d wrong cycles, ready high %0d, required 0 0", w2, errs2, rdy_hi);
    else pass_cnt++;
    @(negedge clk);
    $display("tx 8N1 a5 errs=%0d, back-to-back %02h errs=%0d", errs1, w2, errs2);
  endtask

  task automatic test_tx_random;
    logic [7:0] d;
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      d = 8'($urandom);
      send_tx_a(d, "tx_rand");
    end
  endtask

  task automatic test_loopback_7e2;
    logic [6:0] d;
    int t, k, low_cnt, rise;
    bit rdy_done;
    for (int n = 0; n < 3; n++) begin
      d = (n == 0) ? 7'h55 : 7'($urandom);
      @(negedge clk);
      l_tx_data = d;
      l_tx_valid = 1'b1;
      t = 0;
      while (!l_tx_ready && t < 400) begin @(negedge clk); t++; end
      @(negedge clk);
      l_tx_valid = 1'b0;
      k = 0; low_cnt = 0; rise = -1; rdy_done = 0;
      while (k < 400 && !(rdy_done && rise >= 0)) begin
        if (k > 0) @(negedge clk);
        if (!rdy_done) begin
          if (!l_tx_ready) low_cnt++;
          else rdy_done = 1;
        end
        if (l_rx_valid && rise < 0) rise = k;
        k++;
      end
      chk_cnt++;
      if (rise < 0) $display("FAIL lb_valid: rx_valid never rose in 400 cycles, required 1");
      else pass_cnt++;
      chk_cnt++;
      if (l_rx_data !== d) $display("FAIL lb_data: rx_data=%02h, required %02h", l_rx_data, d);
      else pass_cnt++;
      chk_cnt++;
      if ({l_perr, l_ferr, l_ovr} !== 3'b000) $display("FAIL lb_flags: perr/ferr/ovr=%b, required 000", {l_perr, l_ferr, l_ovr});
      else pass_cnt++;
      chk_cnt++;
      if (low_cnt != 176) $display("FAIL lb_len: frame %0d cycles, required 176", low_cnt);
      else pass_cnt++;
      @(negedge clk); l_rx_ready = 1'b1;
      @(negedge clk); l_rx_ready = 1'b0;
      chk_cnt++;
      if (l_rx_valid !== 1'b0) $display("FAIL lb_consume: rx_valid=%b, required 0", l_rx_valid);
      else pass_cnt++;
      $display("loopback 7E2 data=%02h rx=%02h len=%0d", d, l_rx_data, low_cnt);
    end
  endtask

  task automatic test_rx_errors;
    logic [7:0] d;
    int rise, fall;
    // parity flipped
    drive_line(1, mk_frame(8'h0F, 8, 1, 1'b1, 1'b0), frame_len(8, 1, 1), -1, -1, -1, rise, fall);
    chk_cnt++;
    if ({o_rx_valid, o_rx_data, o_perr, o_ferr} !== {1'b1, 8'h0F, 1'b1, 1'b0})
      $display("FAIL rx_parity: valid=%b data=%02h perr=%b ferr=%b, required 1 0f 1 0", o_rx_valid, o_rx_data, o_perr, o_ferr);
    else pass_cnt++;
    $display("rx parity-flip frame data=%02h perr=%b", o_rx_data, o_perr);
    pulse_ready(1);
    // stop bit low
    d = 8'($urandom);
    drive_line(1, mk_frame(d, 8, 1, 1'b0, 1'b1), frame_len(8, 1, 1), -1, -1, -1, rise, fall);
    chk_cnt++;
    if ({o_rx_valid, o_rx_data, o_perr, o_ferr} !== {1'b1, d, 1'b0, 1'b1})
      $display("FAIL rx_frame: valid=%b data=%02h perr=%b ferr=%b, required 1 %02h 0 1", o_rx_valid, o_rx_data, o_perr, o_ferr, d);
    else pass_cnt++;
    $display("rx bad-stop frame data=%02h ferr=%b", o_rx_data, o_ferr);
    pulse_ready(1);
    chk_cnt++;
    if (o_rx_valid !== 1'b0) $display("FAIL rx_consume: rx_valid=%b, required 0", o_rx_valid);
    else pass_cnt++;
    // idle glitch
    drive_line(1, 16'hFFFF, 0, 0, -1, -1, rise, fall);
    chk_cnt++;
    if (rise != -1 || o_rx_valid !== 1'b0) $display("FAIL rx_idle_glitch: rx_valid rose at %0d, required none", rise);
    else pass_cnt++;
    $display("rx idle glitch rise=%0d", rise);
    // glitch mid data bit 3
    d = 8'($urandom);
    drive_line(1, mk_frame(d, 8, 1, 1'b0, 1'b0), frame_len(8, 1, 1), 16 * 4 + 8, -1, -1, rise, fall);
    chk_cnt++;
    if ({o_rx_valid, o_rx_data, o_perr, o_ferr} !== {1'b1, d, 1'b0, 1'b0})
      $display("FAIL rx_bit_glitch: valid=%b data=%02h perr=%b ferr=%b, required 1 %02h 0 0", o_rx_valid, o_rx_data, o_perr, o_ferr, d);
    else pass_cnt++;
    $display("rx data-glitch frame data=%02h rx=%02h", d, o_rx_data);
    pulse_ready(1);
  endtask

  task automatic test_rx_random;
    logic [7:0] d;
    int kind, rise, fall;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      kind = $urandom_range(0, 2);
      drive_line(1, mk_frame(d, 8, 1, kind == 1, kind == 2), frame_len(8, 1, 1), -1, -1, -1, rise, fall);
      chk_cnt++;
      if ({o_rx_valid, o_rx_data, o_perr, o_ferr, o_ovr} !== {1'b1, d, kind == 1, kind == 2, 1'b0})
        $display("FAIL rx_rand: kind=%0d valid=%b data=%02h perr=%b ferr=%b ovr=%b, required 1 %02h %b %b 0",
                 kind, o_rx_valid, o_rx_data, o_perr, o_ferr, o_ovr, d, kind == 1, kind == 2);
      else pass_cnt++;
      $display("rx random kind=%0d data=%02h rx=%02h", kind, d, o_rx_data);
      pulse_ready(1);
    end
  endtask

  task automatic test_overrun;
    int rise, fall, n44;
    logic [7:0] d44;
    drive_line(0, mk_frame(8'h11, 8, 0, 1'b0, 1'b0), 10, -1, -1, -1, rise, fall);
    drive_line(0, mk_frame(8'h22, 8, 0, 1'b0, 1'b0), 10, -1, -1, -1, rise, fall);
    chk_cnt++;
    if ({a_rx_valid, a_rx_data, a_ovr, a_perr, a_ferr} !== {1'b1, 8'h11, 1'b1, 1'b0, 1'b0})
      $display("FAIL ovr_set: valid=%b data=%02h ovr=%b perr=%b ferr=%b, required 1 11 1 0 0", a_rx_valid, a_rx_data, a_ovr, a_perr, a_ferr);
    else pass_cnt++;
    $display("overrun after 11,22: data=%02h ovr=%b", a_rx_data, a_ovr);
    pulse_ready(0);
    chk_cnt++;
    if ({a_rx_valid, a_ovr, a_rx_data} !== {1'b0, 1'b0, 8'h11})
      $display("FAIL ovr_clear: valid=%b ovr=%b data=%02h, required 0 0 11", a_rx_valid, a_ovr, a_rx_data);
    else pass_cnt++;
    d44 = 8'($urandom);
    drive_line(0, mk_frame(d44, 8, 0, 1'b0, 1'b0), 10, -1, -1, -1, n44, fall);
    chk_cnt++;
    if (n44 < 1 || a_rx_data !== d44) $display("FAIL ovr_pre: rise=%0d data=%02h, required >0 %02h", n44, a_rx_data, d44);
    else pass_cnt++;
    drive_line(0, mk_frame(8'h33, 8, 0, 1'b0, 1'b0), 10, -1, n44 - 1, -1, rise, fall);
    chk_cnt++;
    if ({a_rx_valid, a_rx_data, a_ovr} !== {1'b1, 8'h33, 1'b0} || fall != -1)
      $display("FAIL ovr_same_cycle: valid=%b data=%02h ovr=%b fall=%0d, required 1 33 0 -1", a_rx_valid, a_rx_data, a_ovr, fall);
    else pass_cnt++;
    $display("same-cycle consume+complete: data=%02h ovr=%b", a_rx_data, a_ovr);
    pulse_ready(0);
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    logic [15:0] f;
    int t, rise, fall;
    // TX: reset during data bit 3 (forced low)
    d = 8'($urandom) & 8'hF7;
    f = mk_frame(d, 8, 0, 1'b0, 1'b0);
    @(negedge clk);
    a_tx_data = d;
    a_tx_valid = 1'b1;
    t = 0;
    while (!a_tx_ready && t < 400) begin @(negedge clk); t++; end
    @(negedge clk);
    a_tx_valid = 1'b0;
    repeat (69) @(negedge clk);
    chk_cnt++;
    if (a_tx !== f[4]) $display("FAIL rst_tx_pre: tx=%b in bit 3, required %b", a_tx, f[4]);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (a_tx !== 1'b1 || a_tx_ready !== 1'b1) $display("FAIL rst_tx_async: tx=%b ready=%b, required 1 1", a_tx, a_tx_ready);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    $display("reset during tx bit 3: tx=%b", a_tx);
    send_tx_a(8'($urandom), "tx_after_rst");
    // RX: reset during data bit 4
    d = 8'($urandom);
    drive_line(1, mk_frame(d, 8, 1, 1'b0, 1'b0), frame_len(8, 1, 1), -1, -1, 16 * 5 + 8, rise, fall);
    chk_cnt++;
    if (rise != -1 || o_rx_valid !== 1'b0) $display("FAIL rst_rx_drop: rx_valid rose at %0d, required none", rise);
    else pass_cnt++;
    d = 8'($urandom);
    drive_line(1, mk_frame(d, 8, 1, 1'b0, 1'b0), frame_len(8, 1, 1), -1, -1, -1, rise, fall);
    chk_cnt++;
    if ({o_rx_valid, o_rx_data, o_perr, o_ferr} !== {1'b1, d, 1'b0, 1'b0})
      $display("FAIL rst_rx_next: valid=%b data=%02h perr=%b ferr=%b, required 1 %02h 0 0", o_rx_valid, o_rx_data, o_perr, o_ferr, d);
    else pass_cnt++;
    $display("reset during rx bit 4, next frame data=%02h rx=%02h", d, o_rx_data);
    pulse_ready(1);
  endtask

  initial begin
    test_reset();
    test_tx_8n1();
    test_tx_random();
    test_loopback_7e2();
    test_rx_errors();
    test_rx_random();
    test_overrun();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_cfg_core.md
# uart_cfg_core

Parametrised full-duplex UART core: a configurable-width, configurable-framing successor to the fixed 8N1 115200-baud UART. It provides a valid/ready transmit interface and a one-entry receive holding register. Received bits are taken by 16x oversampling with 3-sample majority vote, and parity, framing and overrun errors are reported. It sits between the chip pins and any byte-stream client in the top-level wrapper.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- BAUD, 115200, line rate; DIV = CLK_HZ/(BAUD*16), truncated, must be >= 1 (defaults give DIV = 27)
- DATA_BITS, 8, data bits per frame, legal 5..8
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, transmitted stop bits, 1 or 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- tx_data  in  DATA_BITS  word to send, LSB first
- tx_valid  in  1  client offers tx_data
- tx_ready  out  1  transmitter idle; transfer on tx_valid && tx_ready
- tx  out  1  serial output, idle high
- rx  in  1  serial input, asynchronous to clk
- rx_data  out  DATA_BITS  received word
- rx_valid  out  1  rx_data and error flags valid
- rx_ready  in  1  client consumes; transfer on rx_valid && rx_ready
- rx_parity_err  out  1  parity mismatch on the held word
- rx_frame_err  out  1  stop bit sampled low on the held word
- rx_overrun  out  1  at least one frame lost since the held word loaded

## Operation
- Tick generator: free-running counter 0..DIV-1 that pulses `tick` when it reaches DIV-1. It runs from reset and is shared by RX and TX.
- TX FSM: IDLE -> START -> DATA (DATA_BITS bits) -> PARITY (skipped if PARITY=0) -> STOP (STOP_BITS bits) -> IDLE.
  - Each bit lasts 16 ticks, counted by a 4-bit sub-counter.
  - On accept, tx_data is latched and the FSM enters START.
  - tx_ready = (state == IDLE).
  - Odd parity bit = ~^data; even parity bit = ^data.
- RX sync: 2-flop synchroniser, both flops reset to 1. All RX decisions use the synchronised value.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - IDLE: a low sample on a tick enters START with sub-count 0.
  - START: at sub-count 7, if the line is high this is a false start; return to IDLE with no output.
  - DATA/PARITY/STOP: each bit value is the majority of samples at sub-counts 7, 8 and 9. Bit advance occurs at sub-count 15.
  - STOP: the frame completes at sub-count 9 of the first stop bit, and the FSM returns to IDLE. This permits back-to-back frames and tolerates a ±3% rate mismatch.
  - The receiver checks only one stop bit regardless of STOP_BITS.
- Completion write:
  - If rx_valid == 0, or rx_valid && rx_ready in the same cycle: load rx_data, rx_parity_err, rx_frame_err; set rx_valid = 1; clear rx_overrun.
  - Otherwise: discard the new frame, set rx_overrun = 1, and leave rx_data and the error flags unchanged.
- rx_valid && rx_ready with no simultaneous completion: rx_valid <= 0 and rx_overrun <= 0. rx_data holds its value.
- Frames with errors are still delivered. Flags describe only the held word.
- rx_parity_err is 0 when PARITY = 0.

## Timing
- Reset values:
  - tx = 1, tx_ready = 1
  - rx_valid = 0, rx_data = 0, all error flags = 0
  - both FSMs in IDLE, all counters 0
- Reset asserted mid-frame aborts immediately: tx goes high asynchronously and any partial RX frame is dropped.
- Bit period = 16*DIV clk cycles.
- TX: the sub-counter and tick phase align to the next tick after accept. The start bit appears on tx within DIV cycles of accept.
- TX frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * 16 * DIV cycles.
- tx_ready rises in the cycle after the last stop-bit tick. tx_valid held high re-accepts in that cycle (zero idle gap beyond the stop bits).
- tx_data is sampled only at accept; changes while busy are ignored.
- RX latency: rx_valid rises 1 cycle after the completion tick. That is about 2 sync cycles + (1 + DATA_BITS + P + 0.5) bit periods after the falling edge of the start bit.
- rx_valid stays high until consumed. Consume and completion in the same cycle load the new word without asserting overrun.

## Test plan
Use CLK_HZ=1600000 and BAUD=100000 (DIV = 1, bit = 16 cycles) unless stated otherwise.

- **Reset and idle:** hold rst_n low, then release → tx = 1, tx_ready = 1, rx_valid = 0, all flags 0; no tx transition for 1000 cycles.
- **TX 8N1:** send 0xA5 → tx = start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each 16 cycles; tx_ready low for 160 cycles. A second word held valid starts with no gap.
- **Loopback 7E2** (DATA_BITS=7, PARITY=2, STOP_BITS=2), tx wired to rx: send 0x55 → rx_data = 0x55, rx_valid = 1, rx_parity_err = 0, rx_frame_err = 0; frame is 176 cycles.
- **RX errors** (8O1):
  - drive a frame for 0x0F with the parity bit flipped → rx_parity_err = 1, rx_data = 0x0F;
  - next frame with the stop bit low → rx_frame_err = 1;
  - a single-cycle glitch low on idle rx → no rx_valid;
  - a single-cycle glitch inside a data bit at sample 8 → majority keeps the correct bit.
- **Overrun:** send 0x11, 0x22 with rx_ready = 0 → rx_data = 0x11, rx_overrun = 1. Pulse rx_ready → rx_valid = 0 and rx_overrun = 0. Completion of 0x33 in the same cycle as rx_ready → rx_data = 0x33, rx_overrun = 0.
- **Reset mid-frame:** assert rst_n during TX bit 3 and during RX bit 4 → tx = 1 immediately, no rx_valid. The next full frame after release is received correctly.
